event_fifo_mode: RTL

//  Parametrised synchronous FIFO; next generation of the event-path FIFO used between monitor

---
 rtl/event_fifo_mode_pkg.sv | 13 +
 rtl/event_fifo_mode_if.sv | 41 ++++
 rtl/event_fifo_mode_wrap_ptr.sv | 22 ++
 rtl/event_fifo_mode.sv | 138 +++++++++++++
 4 files changed

// File: rtl/event_fifo_mode_pkg.sv
// Shared types and constants for the event-path FIFO.
// The optional statistics block is enabled by defining FIFO_STATS_EN.
package event_fifo_pkg;

  // What happens to a push that arrives while the FIFO is full and no pop is present.
  typedef enum logic {
    OVF_DROP_NEW,
    OVF_DROP_OLDEST
  } ovf_policy_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/event_fifo_mode_if.sv
// Bus between the event producer/consumer and the event FIFO.
// master = capture/drain side, slave = the FIFO itself.
interface event_fifo_mode_if
  import event_fifo_pkg::*;
#(
  parameter int W     = 72,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);

  // push/pop are single-cycle requests sampled every posedge; there is no ready,
  // refusal is reported afterwards through the overflow/underflow pulses.
  logic              push;
  logic [W-1:0]      push_data;
  logic              pop;
  logic [W-1:0]      pop_data;
  logic [W-1:0]      peek_data;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              stats_clr;
  logic [STAT_W-1:0] drop_count;
  logic [CW-1:0]     high_water;

  modport master (
    output push, push_data, pop, stats_clr,
    input  pop_data, peek_data, empty, full, almost_empty, almost_full,
    input  count, overflow, underflow, drop_count, high_water
  );

  modport slave (
    input  push, push_data, pop, stats_clr,
    output pop_data, peek_data, empty, full, almost_empty, almost_full,
    output count, overflow, underflow, drop_count, high_water
  );

endinterface

// File: rtl/event_fifo_mode_wrap_ptr.sv
// Storage pointer for the event FIFO; wraps explicitly at DEPTH-1 so any depth works.
module fifo_wrap_ptr #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/event_fifo_mode.sv
// Event-path FIFO: arbitrary depth, watermarks, drop-new/drop-oldest overflow policy.
// Occupancy/drop statistics are built only when FIFO_STATS_EN is defined.
module event_fifo_mode
  import event_fifo_pkg::*;
#(
  parameter int          W         = 72,
  parameter int          DEPTH     = 4,
  parameter int          AF_THRESH = DEPTH - 1,
  parameter int          AE_THRESH = 1,
  parameter ovf_policy_e POLICY    = OVF_DROP_NEW
) (
  input logic              clk,
  input logic              rst,
  event_fifo_mode_if.slave fif
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  pop_data_q;
  logic          ovf_q;
  logic          unf_q;

  logic is_empty;
  logic is_full;
  logic do_pop;
  logic drop_head;
  logic wr_inc;
  logic rd_inc;
  logic ovf_nxt;
  logic unf_nxt;

  // All decisions use the pre-edge occupancy. A pop on an empty FIFO never
  // bypasses the push; a push on a full FIFO is taken only if a slot frees up
  // this cycle (real pop) or the policy sacrifices the head.
  always_comb begin
    is_empty  = (count_q == '0);
    is_full   = (count_q == FULL);
    do_pop    = fif.pop && !is_empty;
    drop_head = fif.push && !fif.pop && is_full && (POLICY == OVF_DROP_OLDEST);
    wr_inc    = fif.push && (!is_full || do_pop || drop_head);
    rd_inc    = do_pop || drop_head;
    ovf_nxt   = fif.push && !fif.pop && is_full;
    unf_nxt   = fif.pop && is_empty;
  end

  always_comb begin
    count_nxt = count_q;
    if (wr_inc && !rd_inc) begin
      count_nxt = count_q + 1'b1;
    end else if (rd_inc && !wr_inc) begin
      count_nxt = count_q - 1'b1;
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_inc),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_inc),
    .ptr (rd_ptr)
  );

  // Storage has no reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (wr_inc) begin
      mem[wr_ptr] <= fif.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      pop_data_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
      // A head discarded by the overflow policy is never presented on pop_data.
      if (do_pop) begin
        pop_data_q <= mem[rd_ptr];
      end
    end
  end

  assign fif.pop_data     = pop_data_q;
  assign fif.peek_data    = is_empty ? '0 : mem[rd_ptr];
  assign fif.empty        = is_empty;
  assign fif.full         = is_full;
  assign fif.almost_empty = (count_q <= AE_C);
  assign fif.almost_full  = (count_q >= AF_C);
  assign fif.count        = count_q;
  assign fif.overflow     = ovf_q;
  assign fif.underflow    = unf_q;

`ifdef FIFO_STATS_EN
  logic [STAT_W-1:0] drop_q;
  logic [CW-1:0]     hw_q;

  // Clear has priority over a same-cycle update; drop counter saturates.
  always_ff @(posedge clk) begin
    if (rst || fif.stats_clr) begin
      drop_q <= '0;
      hw_q   <= '0;
    end else begin
      if (ovf_nxt && (drop_q != {STAT_W{1'b1}})) begin
        drop_q <= drop_q + 1'b1;
      end
      if (count_nxt > hw_q) begin
        hw_q <= count_nxt;
      end
    end
  end

  assign fif.drop_count = drop_q;
  assign fif.high_water = hw_q;
`else
  assign fif.drop_count = '0;
  assign fif.high_water = '0;
`endif

endmodule
